// File: rtl/rr_demux_sched.sv
// rtl/rr_demux_sched.sv - round-robin scheduler driving a 1-to-8 enable-gated demux
//
// Shares one 1-to-8 demux among 8 requesters. A winner is picked in IDLE by
// scanning req from ptr upward (wrapping 7 -> 0). Its grant is registered and
// held until it is released, and a guard gap follows every release.
//
// Parameters:
//   GAP_CYCLES  idle cycles between release and next arbitration (1..15)
//   MAX_HOLD    max cycles a grant may be held, ARB_TIMEOUT_EN only (2..255)
//
// Optional feature macro: ARB_TIMEOUT_EN (forced release after MAX_HOLD cycles)
//
// Ports:
//   clk      in   1  clock, rising edge
//   rst      in   1  asynchronous active-high reset
//   req      in   8  per-channel request
//   done     in   1  granted requester finished, releases the grant
//   sel      out  3  demux select = index of granted channel
//   en       out  1  demux enable, high while a grant is active
//   gnt      out  8  one-hot grant, gnt[sel] = en
//   busy     out  1  high whenever state != IDLE
//   timeout  out  1  1-cycle pulse on forced release
module rr_demux_sched #(
  parameter int GAP_CYCLES = 1,
  parameter int MAX_HOLD   = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  input  logic       done,
  output logic [2:0] sel,
  output logic       en,
  output logic [7:0] gnt,
  output logic       busy,
  output logic       timeout
);

  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

  state_t     state, state_nxt;
  logic [2:0] ptr, ptr_nxt;
  logic [2:0] winner;
  logic       found;
  logic [3:0] gap_cnt, gap_cnt_nxt;
  logic       norm_rel;
  logic       force_rel;
  logic       do_rel;
  logic [2:0] sel_nxt;
  logic       en_nxt;
  logic [7:0] gnt_nxt;
  logic       busy_nxt;
  logic       timeout_nxt;

  // First set request at or after ptr, wrapping 7 -> 0.
  always_comb begin
    winner = ptr;
    found  = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (!found && req[ptr + 3'(i)]) begin
        winner = ptr + 3'(i);
        found  = 1'b1;
      end
    end
  end

  // done and a dropped request together still make one release.
  assign norm_rel = done || !req[sel];

`ifdef ARB_TIMEOUT_EN
  logic [7:0] hold_cnt;

  // Cleared everywhere outside GRANT, so it starts at 0 on GRANT entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      hold_cnt <= 8'd0;
    else if (state != GRANT)
      hold_cnt <= 8'd0;
    else if (hold_cnt != 8'hFF)
      hold_cnt <= hold_cnt + 8'd1;
  end

  // A normal release in the same cycle wins, so no timeout pulse then.
  assign force_rel = (state == GRANT) && !norm_rel && (hold_cnt == 8'(MAX_HOLD - 1));
`else
  logic [7:0] unused_max_hold;
  assign unused_max_hold = 8'(MAX_HOLD);
  assign force_rel       = 1'b0;
`endif

  assign do_rel = (state == GRANT) && (norm_rel || force_rel);

  // State register and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      ptr     <= 3'd0;
      gap_cnt <= 4'd0;
      sel     <= 3'd0;
      en      <= 1'b0;
      gnt     <= 8'd0;
      busy    <= 1'b0;
      timeout <= 1'b0;
    end else begin
      state   <= state_nxt;
      ptr     <= ptr_nxt;
      gap_cnt <= gap_cnt_nxt;
      sel     <= sel_nxt;
      en      <= en_nxt;
      gnt     <= gnt_nxt;
      busy    <= busy_nxt;
      timeout <= timeout_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|req)           state_nxt = GRANT;
      GRANT:   if (do_rel)         state_nxt = GAP;
      GAP:     if (gap_cnt == 4'd0) state_nxt = IDLE;
      default:                     state_nxt = IDLE;
    endcase
  end

  // Next values of the registered outputs and datapath.
  always_comb begin
    sel_nxt     = sel;
    en_nxt      = en;
    gnt_nxt     = gnt;
    ptr_nxt     = ptr;
    gap_cnt_nxt = gap_cnt;
    timeout_nxt = 1'b0;
    busy_nxt    = (state_nxt != IDLE);
    case (state)
      IDLE: begin
        if (|req) begin
          sel_nxt = winner;
          en_nxt  = 1'b1;
          gnt_nxt = 8'b1 << winner;
        end
      end
      GRANT: begin
        if (do_rel) begin
          en_nxt      = 1'b0;
          gnt_nxt     = 8'd0;
          ptr_nxt     = sel + 3'd1;
          gap_cnt_nxt = 4'(GAP_CYCLES - 1);
          timeout_nxt = force_rel;
        end
      end
      GAP: begin
        if (gap_cnt != 4'd0)
          gap_cnt_nxt = gap_cnt - 4'd1;
      end
      default: begin
        en_nxt  = 1'b0;
        gnt_nxt = 8'd0;
      end
    endcase
  end

endmodule

// File: tb/tb_rr_demux_sched.sv
// tb/tb_rr_demux_sched.sv - directed self-checking bench for rr_demux_sched
module tb_rr_demux_sched;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] req = 8'd0;
  logic       done = 1'b0;
  logic [2:0] sel;
  logic       en;
  logic [7:0] gnt;
  logic       busy;
  logic       timeout;

  logic [7:0] req3 = 8'd0;
  logic       done3 = 1'b0;
  logic [2:0] sel3;
  logic       en3;
  logic [7:0] gnt3;
  logic       busy3;
  logic       timeout3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rr_demux_sched #(.GAP_CYCLES(1), .MAX_HOLD(4)) u_dut (
    .clk(clk), .rst(rst), .req(req), .done(done),
    .sel(sel), .en(en), .gnt(gnt), .busy(busy), .timeout(timeout)
  );

  rr_demux_sched #(.GAP_CYCLES(3), .MAX_HOLD(4)) u_dut3 (
    .clk(clk), .rst(rst), .req(req3), .done(done3),
    .sel(sel3), .en(en3), .gnt(gnt3), .busy(busy3), .timeout(timeout3)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    step();
    step();
    check("rst_sel", sel, 0);
    check("rst_en", en, 0);
    check("rst_gnt", gnt, 0);
    check("rst_busy", busy, 0);
    check("rst_timeout", timeout, 0);
    rst = 1'b0;
    step();

    // Two requesters from ptr 0: ch2 first, then ch5 after the gap.
    req = 8'b0010_0100;
    step();
    check("t2_sel", sel, 2);
    check("t2_en", en, 1);
    check("t2_gnt", gnt, 8'h04);
    check("t2_busy", busy, 1);
    done = 1'b1;
    step();
    done = 1'b0;
    check("t2_rel_en", en, 0);
    check("t2_rel_gnt", gnt, 0);
    check("t2_rel_sel", sel, 2);
    check("t2_rel_busy", busy, 1);
    step();
    check("t2_idle_en", en, 0);
    check("t2_idle_busy", busy, 0);
    step();
    check("t2_sel5", sel, 5);
    check("t2_gnt5", gnt, 8'h20);
    req = 8'd0;
    step();
    check("t2_drop_en", en, 0);
    step();
    step();
    check("t2_noreq_busy", busy, 0);

    // ptr is 6 here; ch3 wins by wrap, then drop req and done together.
    req = 8'h08;
    step();
    check("t4_sel3", sel, 3);
    check("t4_gnt3", gnt, 8'h08);
    req = 8'h00;
    done = 1'b1;
    step();
    done = 1'b0;
    req = 8'h18;
    check("t4_rel_en", en, 0);
    check("t4_rel_busy", busy, 1);
    step();
    check("t4_gap_busy", busy, 0);
    step();
    check("t4_ptr4", sel, 4);
    done = 1'b1;
    req = 8'h08;
    step();
    done = 1'b0;
    step();
    step();
    check("t4_regrant3", sel, 3);
    check("t4_regrant_en", en, 1);

    // Reset asserted mid-grant takes effect immediately.
    req = 8'h20;
    done = 1'b1;
    step();
    done = 1'b0;
    step();
    step();
    check("t1_pre_sel", sel, 5);
    check("t1_pre_en", en, 1);
    rst = 1'b1;
    #1;
    check("t1_async_en", en, 0);
    check("t1_async_gnt", gnt, 0);
    check("t1_async_sel", sel, 0);
    check("t1_async_busy", busy, 0);
    req = 8'h24;
    step();
    rst = 1'b0;
    step();
    check("t1_first_lowest", sel, 2);

    // All eight requesting: strict rotation with wrap.
    req = 8'd0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    req = 8'hFF;
    step();
    for (int k = 0; k < 9; k++) begin
      check($sformatf("t3_sel%0d", k), sel, k % 8);
      check($sformatf("t3_gnt%0d", k), gnt, 8'h01 << (k % 8));
      done = 1'b1;
      step();
      done = 1'b0;
      step();
      step();
    end

    // Held request with no done.
    req = 8'd0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    req = 8'h01;
    step();
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t5_hold_en%0d", i), en, 1);
      check($sformatf("t5_hold_to%0d", i), timeout, 0);
      if (i < 3) step();
    end
    step();
`ifdef ARB_TIMEOUT_EN
    check("t5_force_en", en, 0);
    check("t5_force_to", timeout, 1);
    step();
    check("t5_to_pulse_end", timeout, 0);
    check("t5_idle_busy", busy, 0);
    step();
    check("t5_regrant_en", en, 1);
    check("t5_regrant_sel", sel, 0);
`else
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t5_stay_en%0d", i), en, 1);
      check($sformatf("t5_stay_to%0d", i), timeout, 0);
      step();
    end
`endif
    req = 8'd0;

    // Three-cycle gap on the second instance.
    req3 = 8'h03;
    step();
    check("t6_sel0", sel3, 0);
    check("t6_en0", en3, 1);
    done3 = 1'b1;
    step();
    done3 = 1'b0;
    check("t6_rel_en", en3, 0);
    check("t6_rel_busy", busy3, 1);
    step();
    check("t6_gap1_en", en3, 0);
    check("t6_gap1_busy", busy3, 1);
    step();
    check("t6_gap2_en", en3, 0);
    check("t6_gap2_busy", busy3, 1);
    step();
    check("t6_idle_en", en3, 0);
    check("t6_idle_busy", busy3, 0);
    step();
    check("t6_sel1", sel3, 1);
    check("t6_en1", en3, 1);
    check("t6_gnt1", gnt3, 8'h02);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
